// File: rtl/multiply_ntts_if.sv
// Operand/result bundle for the NTT-domain pointwise multiplier.
// The master side issues start and operands; the slave returns done and h_hat.
interface multiply_ntts_if #(
  parameter int N = 256
);
  logic              start_mul;
  logic              acc_en;
  logic signed [31:0] f_hat  [N];
  logic signed [31:0] g_hat  [N];
  logic signed [31:0] acc_in [N];
  logic              done_mul;
  logic signed [31:0] h_hat  [N];

  modport master (
    output start_mul,
    output acc_en,
    output f_hat,
    output g_hat,
    output acc_in,
    input  done_mul,
    input  h_hat
  );

  modport slave (
    input  start_mul,
    input  acc_en,
    input  f_hat,
    input  g_hat,
    input  acc_in,
    output done_mul,
    output h_hat
  );
endinterface

// File: rtl/multiply_ntts.sv
// Pointwise base-case multiply of two NTT-domain polynomials mod Q,
// one degree-1 pair per cycle through a 2-stage pipeline.
module multiply_ntts #(
  parameter int N    = 256,
  parameter int Q    = 3329,
  parameter int ZETA = 17
) (
  input  logic           clk,
  input  logic           rst,
  multiply_ntts_if.slave bus
);

  localparam int P  = N / 2;
  localparam int CW = $clog2(P);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          drain_cnt;
  logic          done_r;

  logic [11:0] f_r [N];
  logic [11:0] g_r [N];
  logic [11:0] a_r [N];
  logic [11:0] h_r [N];

  logic          s1_vld;
  logic [CW-1:0] s1_idx;
  logic [23:0]   p00;
  logic [23:0]   p01;
  logic [23:0]   p10;
  logic [11:0]   p11;

  logic [11:0] gamma_tab [P];

  logic [CW:0] ev_i;
  logic [CW:0] od_i;
  logic [CW:0] s2_ev;
  logic [CW:0] s2_od;

  function automatic int pow_mod(input int e);
    int r;
    int b;
    r = 1;
    b = ZETA % Q;
    for (int k = 0; k < 16; k++) begin
      if (((e >> k) & 1) == 1) r = (r * b) % Q;
      b = (b * b) % Q;
    end
    return r;
  endfunction

  function automatic int brv(input int i);
    int r;
    r = 0;
    for (int k = 0; k < CW; k++)
      if (((i >> k) & 1) == 1)
        r = r | (1 << (CW - 1 - k));
    return r;
  endfunction

  // Non-negative residue of a signed operand.
  function automatic logic [11:0] red_s32(
    input logic signed [31:0] x
  );
    logic signed [31:0] r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return 12'(r);
  endfunction

  function automatic logic [11:0] red_u26(
    input logic [25:0] x
  );
    logic [25:0] r;
    r = x % 26'(Q);
    return 12'(r);
  endfunction

  // gamma_i = ZETA^(2*BitRev(i)+1), folded at elaboration.
  for (genvar gi = 0; gi < P; gi++) begin : g_rom
    localparam int G = pow_mod(2 * brv(gi) + 1);
    assign gamma_tab[gi] = 12'(G);
  end

  assign ev_i  = {cnt, 1'b0};
  assign od_i  = {cnt, 1'b1};
  assign s2_ev = {s1_idx, 1'b0};
  assign s2_od = {s1_idx, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_mul) state <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(P - 1)) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) state <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        f_r[k] <= '0;
        g_r[k] <= '0;
        a_r[k] <= '0;
        h_r[k] <= '0;
      end
      s1_vld <= 1'b0;
      s1_idx <= '0;
      p00    <= '0;
      p01    <= '0;
      p10    <= '0;
      p11    <= '0;
    end else begin
      // A cleared accumulator makes acc_en=0 a plain multiply.
      if (state == LOAD) begin
        for (int k = 0; k < N; k++) begin
          f_r[k] <= red_s32(bus.f_hat[k]);
          g_r[k] <= red_s32(bus.g_hat[k]);
          a_r[k] <= bus.acc_en ?
                    red_s32(bus.acc_in[k]) : '0;
        end
      end

      s1_vld <= (state == RUN);
      s1_idx <= cnt;
      p00 <= 24'(f_r[ev_i]) * 24'(g_r[ev_i]);
      p01 <= 24'(f_r[ev_i]) * 24'(g_r[od_i]);
      p10 <= 24'(f_r[od_i]) * 24'(g_r[ev_i]);
      p11 <= red_u26(26'(f_r[od_i]) * 26'(g_r[od_i]));

      if (s1_vld) begin
        h_r[s2_ev] <= red_u26(
          26'(p00)
          + 26'(p11) * 26'(gamma_tab[s1_idx])
          + 26'(a_r[s2_ev]));
        h_r[s2_od] <= red_u26(
          26'(p01) + 26'(p10)
          + 26'(a_r[s2_od]));
      end
    end
  end

  assign bus.done_mul = done_r;

  always_comb begin
    for (int k = 0; k < N; k++)
      bus.h_hat[k] = $signed({20'd0, h_r[k]});
  end

endmodule

// File: tb/tb_multiply_ntts.sv
// Directed and random checks of multiply_ntts against hand values
// and an independent MultiplyNTTs model.
module tb_multiply_ntts;

  localparam int N = 256;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multiply_ntts_if #(.N(N)) bus ();

  multiply_ntts #(
    .N(N),
    .Q(Q),
    .ZETA(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int exp_h [N];
  int gam   [N/2];

  function automatic int modq(input longint x);
    longint r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return int'(r);
  endfunction

  task automatic clear_inputs();
    bus.start_mul = 1'b0;
    bus.acc_en    = 1'b0;
    for (int k = 0; k < N; k++) begin
      bus.f_hat[k]  = 0;
      bus.g_hat[k]  = 0;
      bus.acc_in[k] = 0;
    end
  endtask

  task automatic zero_exp();
    for (int k = 0; k < N; k++) exp_h[k] = 0;
  endtask

  // Repeated multiplication, no square-and-multiply.
  task automatic build_gammas();
    for (int i = 0; i < N/2; i++) begin
      int br;
      int p;
      br = 0;
      for (int b = 0; b < 7; b++)
        if (((i >> b) & 1) == 1) br = br | (1 << (6 - b));
      p = 1;
      for (int e = 0; e < 2 * br + 1; e++) p = (p * 17) % Q;
      gam[i] = p;
    end
  endtask

  task automatic model();
    for (int i = 0; i < N/2; i++) begin
      longint a0, a1, b0, b1;
      a0 = modq(bus.f_hat[2*i]);
      a1 = modq(bus.f_hat[2*i+1]);
      b0 = modq(bus.g_hat[2*i]);
      b1 = modq(bus.g_hat[2*i+1]);
      exp_h[2*i]   = modq(a0*b0 + longint'(modq(a1*b1)) * gam[i]);
      exp_h[2*i+1] = modq(a0*b1 + a1*b0);
    end
  endtask

  // Pulse start, count edges from the sampling edge to done.
  task automatic run_op(input int inject_at, output int lat);
    lat = -1;
    bus.start_mul = 1'b1;
    @(posedge clk); #1;
    bus.start_mul = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      bus.start_mul = (n == inject_at);
      @(posedge clk); #1;
      if (bus.done_mul) begin
        lat = n;
        break;
      end
    end
    bus.start_mul = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.done_mul !== 1'b0) begin
      n_bad++;
      $display("FAIL reset done_mul: got %0b want 0", bus.done_mul);
    end
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if (bus.h_hat[k] !== 0) begin
        n_bad++;
        $display("FAIL reset h_hat[%0d]: got %0d want 0", k, bus.h_hat[k]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat;
    clear_inputs();
    bus.f_hat[0] = 1;
    bus.g_hat[0] = 1;
    run_op(0, lat);
    n_vec++;
    if (lat !== 132) begin
      n_bad++;
      $display("FAIL single latency: got %0d want 132", lat);
    end
    zero_exp();
    exp_h[0] = 1;
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if (bus.h_hat[k] !== exp_h[k]) begin
        n_bad++;
        $display("FAIL single h_hat[%0d]: got %0d want %0d",
                 k, bus.h_hat[k], exp_h[k]);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.done_mul !== 1'b0) begin
      n_bad++;
      $display("FAIL single done width: got %0b want 0", bus.done_mul);
    end
  endtask

  task automatic test_gamma();
    int fi [2] = '{1, 3};
    int hi [2] = '{0, 2};
    int hv [2] = '{17, 3312};
    int lat;
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      bus.f_hat[fi[c]] = 1;
      bus.g_hat[fi[c]] = 1;
      run_op(0, lat);
      zero_exp();
      exp_h[hi[c]] = hv[c];
      n_vec++;
      if (lat !== 132) begin
        n_bad++;
        $display("FAIL gamma%0d latency: got %0d want 132", c, lat);
      end
      for (int k = 0; k < N; k++) begin
        n_vec++;
        if (bus.h_hat[k] !== exp_h[k]) begin
          n_bad++;
          $display("FAIL gamma%0d h_hat[%0d]: got %0d want %0d",
                   c, k, bus.h_hat[k], exp_h[k]);
        end
      end
    end
  endtask

  task automatic test_reduction();
    int fi [4] = '{0, 0, 0, 0};
    int fv [4] = '{1, -1, 3328, 3329};
    int gi [4] = '{1, 0, 0, 0};
    int gv [4] = '{1, -1, 3328, 5};
    int hi [4] = '{1, 0, 0, 0};
    int hv [4] = '{1, 1, 1, 0};
    int lat;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      bus.f_hat[fi[c]] = fv[c];
      bus.g_hat[gi[c]] = gv[c];
      run_op(0, lat);
      zero_exp();
      exp_h[hi[c]] = hv[c];
      n_vec++;
      if (lat !== 132) begin
        n_bad++;
        $display("FAIL red%0d latency: got %0d want 132", c, lat);
      end
      for (int k = 0; k < N; k++) begin
        n_vec++;
        if (bus.h_hat[k] !== exp_h[k]) begin
          n_bad++;
          $display("FAIL red%0d h_hat[%0d]: got %0d want %0d",
                   c, k, bus.h_hat[k], exp_h[k]);
        end
      end
    end
  endtask

  task automatic test_accumulate();
    logic ae [2] = '{1'b1, 1'b0};
    int   h0 [2] = '{0, 1};
    int   h5 [2] = '{7, 0};
    int lat;
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      bus.acc_en    = ae[c];
      bus.acc_in[0] = 3328;
      bus.acc_in[5] = 7;
      bus.f_hat[0]  = 1;
      bus.g_hat[0]  = 1;
      run_op(0, lat);
      zero_exp();
      exp_h[0] = h0[c];
      exp_h[5] = h5[c];
      n_vec++;
      if (lat !== 132) begin
        n_bad++;
        $display("FAIL acc%0d latency: got %0d want 132", c, lat);
      end
      for (int k = 0; k < N; k++) begin
        n_vec++;
        if (bus.h_hat[k] !== exp_h[k]) begin
          n_bad++;
          $display("FAIL acc%0d h_hat[%0d]: got %0d want %0d",
                   c, k, bus.h_hat[k], exp_h[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int want;
    clear_inputs();
    for (int k = 0; k < N; k++) begin
      bus.f_hat[k] = $signed(32'($urandom_range(0, Q - 1)));
      bus.g_hat[k] = $signed(32'($urandom_range(0, Q - 1)));
    end
    model();
    bus.start_mul = 1'b1;
    @(posedge clk); #1;
    for (int op = 0; op < 3; op++) begin
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
        @(posedge clk); #1;
        if (bus.done_mul) begin
          lat = n;
          break;
        end
      end
      want = (op == 0) ? 132 : 133;
      n_vec++;
      if (lat !== want) begin
        n_bad++;
        $display("FAIL b2b%0d spacing: got %0d want %0d", op, lat, want);
      end
      for (int k = 0; k < N; k++) begin
        n_vec++;
        if (bus.h_hat[k] !== exp_h[k]) begin
          n_bad++;
          $display("FAIL b2b%0d h_hat[%0d]: got %0d want %0d",
                   op, k, bus.h_hat[k], exp_h[k]);
        end
      end
      if (op < 2) begin
        for (int k = 0; k < N; k++) begin
          bus.f_hat[k] = $signed(32'($urandom_range(0, Q - 1)));
          bus.g_hat[k] = $signed(32'($urandom_range(0, Q - 1)));
        end
        model();
      end else begin
        bus.start_mul = 1'b0;
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    logic seen;
    clear_inputs();
    bus.f_hat[0] = 1;
    bus.g_hat[0] = 1;
    bus.start_mul = 1'b1;
    @(posedge clk); #1;
    bus.start_mul = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    n_vec++;
    if (bus.h_hat[0] !== 1) begin
      n_bad++;
      $display("FAIL abort partial h_hat[0]: got %0d want 1", bus.h_hat[0]);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.done_mul !== 1'b0) begin
      n_bad++;
      $display("FAIL abort done_mul: got %0b want 0", bus.done_mul);
    end
    for (int k = 0; k < N; k++) begin
      n_vec++;
      if (bus.h_hat[k] !== 0) begin
        n_bad++;
        $display("FAIL abort h_hat[%0d]: got %0d want 0", k, bus.h_hat[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (140) begin
      @(posedge clk); #1;
      if (bus.done_mul) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort stray done: got %0b want 0", seen);
    end
    zero_exp();
    exp_h[0] = 1;
    for (int c = 0; c < 2; c++) begin
      run_op((c == 1) ? 60 : 0, lat);
      n_vec++;
      if (lat !== 132) begin
        n_bad++;
        $display("FAIL rerun%0d latency: got %0d want 132", c, lat);
      end
      for (int k = 0; k < N; k++) begin
        n_vec++;
        if (bus.h_hat[k] !== exp_h[k]) begin
          n_bad++;
          $display("FAIL rerun%0d h_hat[%0d]: got %0d want %0d",
                   c, k, bus.h_hat[k], exp_h[k]);
        end
      end
    end
  endtask

  initial begin
    build_gammas();
    test_reset();
    test_single();
    test_gamma();
    test_reduction();
    test_accumulate();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
